// File: rtl/uart_rx_port.sv
// rtl/uart_rx_port.sv - 8N1 serial receiver with first-word-fall-through byte FIFO
module uart_rx_port #(
  parameter int BAUD     = 115200,
  parameter int IN_CLOCK = 10000000,
  parameter int DEPTH    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  input  logic       rd,
  input  logic       clr_err,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       rx_full,
  output logic       overrun,
  output logic       frame_err
);

  localparam int DIV = IN_CLOCK / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(DEPTH);

  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic          syncA;
  logic          rxs;
  logic [2:0]    state;
  logic [CW-1:0] baudCnt;
  logic [2:0]    bitIdx;
  logic [7:0]    shiftReg;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   count;

  logic stopSample, pushReq, frameSet;
  logic fifoEmpty, fifoFull, doPush, doPop, overSet;

  // Preset high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syncA <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      syncA <= uart_rx;
      rxs   <= syncA;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
    end else begin
      case (state)
        IDLE: begin
          baudCnt <= '0;
          if (!rxs) state <= START;
        end
        START: begin
          if (baudCnt == HALF_LAST) begin
            baudCnt <= '0;
            bitIdx  <= '0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            baudCnt <= baudCnt + CW'(1);
          end
        end
        DATA: begin
          if (baudCnt == BIT_LAST) begin
            baudCnt  <= '0;
            shiftReg <= {rxs, shiftReg[7:1]};
            bitIdx   <= bitIdx + 3'd1;
            if (bitIdx == 3'd7) state <= STOP;
          end else begin
            baudCnt <= baudCnt + CW'(1);
          end
        end
        STOP: begin
          if (baudCnt == BIT_LAST) begin
            baudCnt <= '0;
            state   <= rxs ? IDLE : BREAK;
          end else begin
            baudCnt <= baudCnt + CW'(1);
          end
        end
        BREAK: begin
          baudCnt <= '0;
          if (rxs) state <= IDLE;
        end
        default: begin
          baudCnt <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign stopSample = (state == STOP) && (baudCnt == BIT_LAST);
  assign pushReq    = stopSample && rxs;
  assign frameSet   = stopSample && !rxs;

  assign fifoEmpty = (count == '0);
  assign fifoFull  = (count == FULL_CNT);
  assign doPop     = rd && !fifoEmpty;
  // A simultaneous pop frees the slot the push needs.
  assign doPush    = pushReq && (!fifoFull || doPop);
  assign overSet   = pushReq && fifoFull && !doPop;

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= shiftReg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (overSet)      overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
      if (frameSet)     frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

  assign rx_data  = fifoEmpty ? 8'h00 : mem[rdPtr];
  assign rx_ready = !fifoEmpty;
  assign rx_full  = fifoFull;

endmodule

// File: tb/tb_uart_rx_port.sv
// tb/tb_uart_rx_port.sv - scoreboard bench for uart_rx_port at default DIV=86
module tb_uart_rx_port;

  localparam int BIT = 86;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       uart_rx = 1'b1;
  logic       rd = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rx_data;
  logic       rx_ready, rx_full, overrun, frame_err;

  int tests = 0;
  int fails = 0;
  logic [7:0] expQ[$];
  logic [7:0] expByte;

  uart_rx_port dut (
    .clk(clk), .reset(reset), .uart_rx(uart_rx), .rd(rd), .clr_err(clr_err),
    .rx_data(rx_data), .rx_ready(rx_ready), .rx_full(rx_full),
    .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Iteration c drives line bit c/BIT; iteration 819 lines up with the stop-bit sample cycle.
  task automatic sendByte(input logic [7:0] d, input logic stopBit, input logic rdAtStop);
    int k;
    for (int c = 0; c < 10 * BIT; c++) begin
      @(posedge clk); #1;
      k = c / BIT;
      uart_rx = (k == 0) ? 1'b0 : (k == 9) ? stopBit : d[k-1];
      rd = rdAtStop && (c == 9 * BIT + 45);
    end
    @(posedge clk); #1 rd = 1'b0;
  endtask

  task automatic pulseRd();
    @(posedge clk); #1 rd = 1'b1;
    @(posedge clk); #1 rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulseClr();
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle(4);
    @(negedge clk);
    tests++;
    if ({rx_data, rx_ready, rx_full, overrun, frame_err} !== 12'h000) begin
      fails++;
      $display("FAIL reset_state: got data=%h rdy=%b full=%b ov=%b fe=%b, expected all 0",
               rx_data, rx_ready, rx_full, overrun, frame_err);
    end
    @(posedge clk); #1 reset = 1'b1;
    idle(10);
  endtask

  task automatic test_basic();
    sendByte(8'h55, 1'b1, 1'b0); expQ.push_back(8'h55);
    sendByte(8'hA3, 1'b1, 1'b0); expQ.push_back(8'hA3);
    @(negedge clk);
    tests++;
    if (rx_ready !== 1'b1 || rx_data !== expQ[0]) begin
      fails++;
      $display("FAIL basic_first: got rdy=%b data=%h, expected rdy=1 data=%h", rx_ready, rx_data, expQ[0]);
    end
    pulseRd(); expByte = expQ.pop_front();
    tests++;
    if (rx_data !== expQ[0]) begin
      fails++;
      $display("FAIL basic_second: got %h, expected %h", rx_data, expQ[0]);
    end
    pulseRd(); expByte = expQ.pop_front();
    tests++;
    if (rx_ready !== 1'b0 || rx_data !== 8'h00) begin
      fails++;
      $display("FAIL basic_empty: got rdy=%b data=%h, expected rdy=0 data=00", rx_ready, rx_data);
    end
    pulseRd();
    tests++;
    if (rx_ready !== 1'b0 || rx_data !== 8'h00) begin
      fails++;
      $display("FAIL rd_when_empty: got rdy=%b data=%h, expected rdy=0 data=00", rx_ready, rx_data);
    end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 9; i++) begin
      sendByte(8'(i), 1'b1, 1'b0);
      if (i <= 8) expQ.push_back(8'(i));
    end
    @(negedge clk);
    tests++;
    if (rx_full !== 1'b1 || overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_flags: got full=%b ov=%b, expected full=1 ov=1", rx_full, overrun);
    end
    for (int i = 0; i < 8; i++) begin
      expByte = expQ.pop_front();
      tests++;
      if (rx_data !== expByte) begin
        fails++;
        $display("FAIL overrun_order[%0d]: got %h, expected %h", i, rx_data, expByte);
      end
      pulseRd();
    end
    tests++;
    if (rx_ready !== 1'b0 || rx_full !== 1'b0 || overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_drain: got rdy=%b full=%b ov=%b, expected 0 0 1", rx_ready, rx_full, overrun);
    end
    pulseClr();
    tests++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL overrun_clear: got %b, expected 0", overrun);
    end
  endtask

  task automatic test_frame_err();
    sendByte(8'h7E, 1'b0, 1'b0);
    @(negedge clk);
    tests++;
    if (frame_err !== 1'b1 || rx_ready !== 1'b0) begin
      fails++;
      $display("FAIL frame_err_set: got fe=%b rdy=%b, expected fe=1 rdy=0", frame_err, rx_ready);
    end
    idle(3 * 10 * BIT);
    @(negedge clk);
    tests++;
    if (rx_ready !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL break_hold: got rdy=%b ov=%b, expected rdy=0 ov=0", rx_ready, overrun);
    end
    @(posedge clk); #1 uart_rx = 1'b1;
    idle(2 * BIT);
    sendByte(8'h42, 1'b1, 1'b0); expQ.push_back(8'h42);
    @(negedge clk);
    expByte = expQ.pop_front();
    tests++;
    if (rx_ready !== 1'b1 || rx_data !== expByte || frame_err !== 1'b1) begin
      fails++;
      $display("FAIL after_break: got rdy=%b data=%h fe=%b, expected rdy=1 data=%h fe=1",
               rx_ready, rx_data, frame_err, expByte);
    end
    pulseRd();
    pulseClr();
    tests++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL frame_err_clear: got %b, expected 0", frame_err);
    end
  endtask

  task automatic test_glitch();
    @(posedge clk); #1 uart_rx = 1'b0;
    idle(20);
    uart_rx = 1'b1;
    idle(2 * BIT);
    @(negedge clk);
    tests++;
    if (rx_ready !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL glitch: got rdy=%b fe=%b ov=%b, expected 0 0 0", rx_ready, frame_err, overrun);
    end
    sendByte(8'h33, 1'b1, 1'b0); expQ.push_back(8'h33);
    @(negedge clk);
    expByte = expQ.pop_front();
    tests++;
    if (rx_data !== expByte || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL after_glitch: got data=%h fe=%b, expected data=%h fe=0", rx_data, frame_err, expByte);
    end
    pulseRd();
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      sendByte(b, 1'b1, 1'b0); expQ.push_back(b);
    end
    b = 8'hC9;
    sendByte(b, 1'b1, 1'b1);
    expByte = expQ.pop_front();
    expQ.push_back(b);
    @(negedge clk);
    tests++;
    if (overrun !== 1'b0 || rx_full !== 1'b1) begin
      fails++;
      $display("FAIL same_cycle_flags: got ov=%b full=%b, expected ov=0 full=1", overrun, rx_full);
    end
    for (int i = 0; i < 8; i++) begin
      expByte = expQ.pop_front();
      tests++;
      if (rx_data !== expByte) begin
        fails++;
        $display("FAIL same_cycle_order[%0d]: got %h, expected %h", i, rx_data, expByte);
      end
      pulseRd();
    end
    tests++;
    if (rx_ready !== 1'b0) begin
      fails++;
      $display("FAIL same_cycle_drain: got rdy=%b, expected 0", rx_ready);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    int k;
    d = 8'hF0;
    for (int c = 0; c < 5 * BIT + 40; c++) begin
      @(posedge clk); #1;
      k = c / BIT;
      uart_rx = (k == 0) ? 1'b0 : d[k-1];
    end
    reset = 1'b0;
    uart_rx = 1'b1;
    idle(5);
    reset = 1'b1;
    idle(2 * BIT);
    @(negedge clk);
    tests++;
    if (rx_ready !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_idle: got rdy=%b fe=%b ov=%b, expected 0 0 0", rx_ready, frame_err, overrun);
    end
    sendByte(8'h0F, 1'b1, 1'b0); expQ.push_back(8'h0F);
    @(negedge clk);
    expByte = expQ.pop_front();
    tests++;
    if (rx_data !== expByte || frame_err !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_byte: got data=%h fe=%b ov=%b, expected data=%h fe=0 ov=0",
               rx_data, frame_err, overrun, expByte);
    end
    pulseRd();
    tests++;
    if (rx_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_single: got rdy=%b, expected 0", rx_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
